move_scan_sequencer: RTL and testbench

- Engine-side counterpart of control_block. Consumes control_block's `init` and `software_stop` and produces the `gen` and `update` strobes that control_block receives.
- Walks the board one square at a time, handshaking with the per-square move generator, and counts squares yielding legal moves.
- After a full pass it emits a single `update` pulse to commit the result.
- Sits between control_block and the move generator datapath.

---
 rtl/move_scan_sequencer.sv | 104 ++++++++++
 tb/tb_move_scan_sequencer.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/move_scan_sequencer.sv
// move_scan_sequencer: walks the board one square at a time, handshaking
// with the per-square move generator, counts squares that yielded at least
// one legal move, and issues a single update strobe after a complete pass.
module move_scan_sequencer #(
  parameter int NUM_SQUARES = 64,
  parameter int SQ_W        = 6,
  parameter int CNT_W       = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             init,
  input  logic             software_stop,
  input  logic             sq_ack,
  input  logic             move_valid,
  output logic             gen,
  output logic             update,
  output logic [SQ_W-1:0]  square,
  output logic [CNT_W-1:0] move_count,
  output logic             busy,
  output logic             done
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_LOAD   = 3'd1,
    S_SCAN   = 3'd2,
    S_UPDATE = 3'd3,
    S_DONE   = 3'd4
  } state_t;

  localparam logic [SQ_W-1:0]  LAST_SQ = SQ_W'(NUM_SQUARES - 1);
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  state_t           state_q, state_d;
  logic [SQ_W-1:0]  square_q, square_d;
  logic [CNT_W-1:0] count_q, count_d;

  // A generator acknowledge only matters while scanning and not aborting.
  logic scan_ack;
  assign scan_ack = (state_q == S_SCAN) && sq_ack && !software_stop;

  // State and datapath registers; reset clears everything immediately.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= S_IDLE;
      square_q <= '0;
      count_q  <= '0;
    end else begin
      state_q  <= state_d;
      square_q <= square_d;
      count_q  <= count_d;
    end
  end

  // Next-state logic; software_stop outranks every other request.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE: begin
        if (init && !software_stop) state_d = S_LOAD;
      end
      S_LOAD: begin
        state_d = software_stop ? S_IDLE : S_SCAN;
      end
      S_SCAN: begin
        if (software_stop)                       state_d = S_IDLE;
        else if (sq_ack && square_q == LAST_SQ)  state_d = S_UPDATE;
      end
      S_UPDATE: begin
        state_d = software_stop ? S_IDLE : S_DONE;
      end
      S_DONE: begin
        if (software_stop) state_d = S_IDLE;
        else if (init)     state_d = S_LOAD;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Square index and saturating move counter; both hold on abort for debug.
  always_comb begin
    square_d = square_q;
    count_d  = count_q;
    if (state_q == S_LOAD && !software_stop) begin
      square_d = '0;
      count_d  = '0;
    end else if (scan_ack) begin
      if (move_valid && count_q != CNT_MAX) count_d = count_q + 1'b1;
      // The last square is kept rather than wrapped so it stays visible.
      if (square_q != LAST_SQ) square_d = square_q + 1'b1;
    end
  end

  // Moore outputs decoded from the registered state.
  always_comb begin
    gen        = (state_q == S_SCAN);
    update     = (state_q == S_UPDATE);
    busy       = (state_q == S_LOAD) || (state_q == S_SCAN) || (state_q == S_UPDATE);
    done       = (state_q == S_DONE);
    square     = square_q;
    move_count = count_q;
  end

endmodule

// File: tb/tb_move_scan_sequencer.sv
// Directed bench for move_scan_sequencer. Expected pass results are queued
// when a pass is launched and retired when the pass ends (commit or abort).
// A second instance with a 5-bit counter shares all inputs to check saturation.
module tb_move_scan_sequencer;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       init = 1'b0;
  logic       software_stop = 1'b0;
  logic       sq_ack = 1'b0;
  logic       move_valid = 1'b0;
  logic       gen, update, busy, done;
  logic [5:0] square;
  logic [7:0] move_count;
  logic       gen_s, update_s, busy_s, done_s;
  logic [5:0] square_s;
  logic [4:0] move_count_s;

  int total = 0;
  int bad   = 0;

  typedef struct {
    int cnt;
    int cnt_sat;
    int sq;
  } exp_t;
  exp_t sb[$];

  always #5 clk = ~clk;

  move_scan_sequencer #(.NUM_SQUARES(64), .SQ_W(6), .CNT_W(8)) dut (
    .clk(clk), .reset(reset), .init(init), .software_stop(software_stop),
    .sq_ack(sq_ack), .move_valid(move_valid), .gen(gen), .update(update),
    .square(square), .move_count(move_count), .busy(busy), .done(done)
  );

  move_scan_sequencer #(.NUM_SQUARES(64), .SQ_W(6), .CNT_W(5)) dut_sat (
    .clk(clk), .reset(reset), .init(init), .software_stop(software_stop),
    .sq_ack(sq_ack), .move_valid(move_valid), .gen(gen_s), .update(update_s),
    .square(square_s), .move_count(move_count_s), .busy(busy_s), .done(done_s)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    total++;
    assert (obs === exp_v) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp_v);
    end
  endtask

  task automatic check_idle(input string tag);
    check({tag, "_gen"},    gen,    0);
    check({tag, "_update"}, update, 0);
    check({tag, "_busy"},   busy,   0);
    check({tag, "_done"},   done,   0);
  endtask

  // One pass: ack every 'period' cycles, move_valid on squares below 'limit',
  // optional abort at square 'stop_at', optional stray init at 'init_at'.
  task automatic run_pass(input int period, input int limit, input int stop_at, input int init_at);
    exp_t e, g;
    int   n, sq, cyc, scans;
    bit   ack, fin, aborted;
    n = (stop_at >= 0) ? ((stop_at < limit) ? stop_at : limit) : limit;
    e.cnt     = (n > 255) ? 255 : n;
    e.cnt_sat = (n > 31) ? 31 : n;
    e.sq      = (stop_at >= 0) ? stop_at : 63;
    sb.push_back(e);

    init = 1'b1;
    @(negedge clk);
    init = 1'b0;
    check("load_busy", busy, 1);
    check("load_gen",  gen,  0);
    check("load_done", done, 0);
    @(negedge clk);
    check("scan_cnt_clear", move_count,   0);
    check("sat_cnt_clear",  move_count_s, 0);

    sq = 0; cyc = 0; scans = 0; fin = 0; aborted = 0;
    while (!fin && cyc < 64 * period + 8) begin
      check("scan_gen",    gen,    1);
      check("scan_update", update, 0);
      check("scan_square", square, sq);
      scans++;
      ack           = ((cyc % period) == period - 1);
      sq_ack        = ack;
      move_valid    = ack ? (sq < limit) : 1'($urandom_range(1, 0));
      init          = (sq == init_at);
      software_stop = ack && (sq == stop_at);
      @(negedge clk);
      cyc++;
      sq_ack = 1'b0; move_valid = 1'b0; init = 1'b0;
      if (software_stop) begin
        software_stop = 1'b0;
        aborted = 1; fin = 1;
      end else if (ack) begin
        if (sq == 63) fin = 1;
        else sq++;
      end
    end

    if (!fin) begin
      total++; bad++;
      $error("FAIL scan_timeout observed=%0d expected=%0d", cyc, 64 * period);
      return;
    end
    if (sb.size() == 0) begin
      total++; bad++;
      $error("FAIL sb_empty observed=0 expected=1");
      return;
    end
    g = sb.pop_front();

    if (aborted) begin
      check_idle("abort");
      check("abort_count", move_count,   g.cnt);
      check("abort_sat",   move_count_s, g.cnt_sat);
      check("abort_square", square,      g.sq);
      repeat (3) begin
        @(negedge clk);
        check_idle("abort_hold");
        check("abort_count_hold", move_count, g.cnt);
      end
    end else begin
      check("scan_cycles", scans, 64 * period);
      check("upd_pulse",   update, 1);
      check("upd_busy",    busy,   1);
      check("upd_gen",     gen,    0);
      check("upd_count",   move_count,   g.cnt);
      check("upd_sat",     move_count_s, g.cnt_sat);
      check("upd_square",  square,       g.sq);
      @(negedge clk);
      check("done_update", update, 0);
      check("done_flag",   done,   1);
      check("done_busy",   busy,   0);
      check("done_count",  move_count, g.cnt);
      check("done_square", square,     g.sq);
      @(negedge clk);
      check("done_hold",   done,   1);
      check("done_update2", update, 0);
    end
  endtask

  initial begin
    // Reset held two cycles, then ten quiet cycles.
    repeat (2) @(negedge clk);
    check_idle("in_reset");
    check("in_reset_square", square, 0);
    check("in_reset_count",  move_count, 0);
    reset = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check_idle("idle");
      check("idle_square", square, 0);
      check("idle_count",  move_count, 0);
    end

    // init together with software_stop in IDLE is refused.
    init = 1'b1; software_stop = 1'b1;
    @(negedge clk);
    init = 1'b0; software_stop = 1'b0;
    check_idle("init_stop");
    @(negedge clk);
    check_idle("init_stop2");

    // Full pass, valid on squares 0..19.
    run_pass(1, 20, -1, -1);
    // Restart from DONE with a stalled generator and a stray init mid-scan.
    run_pass(3, 64, -1, 30);
    // All squares valid: 8-bit counter reaches 64, 5-bit counter pins at 31.
    run_pass(1, 64, -1, -1);
    // Abort at square 10, coincident with ack and move_valid.
    run_pass(1, 64, 10, -1);

    // Asynchronous reset between edges during a scan.
    init = 1'b1;
    @(negedge clk);
    init = 1'b0;
    @(negedge clk);
    sq_ack = 1'b1; move_valid = 1'b1;
    repeat (5) @(negedge clk);
    check("pre_reset_gen",   gen,        1);
    check("pre_reset_count", move_count, 5);
    #2 reset = 1'b1;
    #1;
    check("async_gen",    gen,        0);
    check("async_busy",   busy,       0);
    check("async_count",  move_count, 0);
    check("async_square", square,     0);
    sq_ack = 1'b0; move_valid = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check_idle("post_reset");
    check("sb_drained", sb.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #1ms;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
